// File: rtl/ap_trigger_if.sv
// Trigger request bus between the actionpoint trigger stage
// and pipeline control: request, type, capture, and accept.
interface ap_trigger_if;
  logic        ap_req;
  logic        ap_req_halt;
  logic        ap_ack;
  logic [2:0]  ap_hit_id_r;
  logic [31:0] ap_hit_value_r;

  modport master (
    output ap_req, ap_req_halt,
    output ap_hit_id_r, ap_hit_value_r,
    input  ap_ack
  );

  modport slave (
    input  ap_req, ap_req_halt,
    input  ap_hit_id_r, ap_hit_value_r,
    output ap_ack
  );
endinterface

// File: rtl/ap_trigger.sv
// Actionpoint trigger stage: pairing, sticky status,
// first-trigger capture and halt/breakpoint request handshake.
module ap_trigger #(
  parameter int NUM_AP      = 4,
  parameter int PAIR_WINDOW = 3
) (
  input  logic                 clk_debug,
  input  logic                 rst_a,
  input  logic                 en_debug_r,
  input  logic [NUM_AP-1:0]    ap_hit_vec,
  input  logic [NUM_AP*32-1:0] ap_hit_value_flat,
  input  logic [NUM_AP/2-1:0]  ap_pair_en,
  input  logic [NUM_AP-1:0]    ap_action,
  input  logic                 asr_clear,
  output logic [NUM_AP-1:0]    asr_r,
  ap_trigger_if.master         bus
);
  localparam int NP = NUM_AP / 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [NUM_AP-1:0] h;
  logic [NUM_AP-1:0] trig;
  logic [3:0]        cnt     [NP];
  logic [3:0]        cnt_nxt [NP];
  logic              any_trig;
  logic              capture;
  logic              clr_eff;
  logic [2:0]        first_id;
  logic [31:0]       first_val;
  logic              halt_nxt;

  assign h = ap_hit_vec & {NUM_AP{en_debug_r}};

  // cnt holds the number of window cycles still open after arming
  always_comb begin
    trig = h;
    for (int p = 0; p < NP; p++) begin
      cnt_nxt[p] = '0;
      if (ap_pair_en[p]) begin
        trig[2*p]   = 1'b0;
        trig[2*p+1] = h[2*p+1] & (h[2*p] | (cnt[p] != '0));
        if (h[2*p])
          cnt_nxt[p] = 4'(PAIR_WINDOW);
        else if (trig[2*p+1])
          cnt_nxt[p] = '0;
        else if (cnt[p] != '0)
          cnt_nxt[p] = cnt[p] - 4'd1;
      end
    end
  end

  always_comb begin
    first_id  = '0;
    first_val = '0;
    for (int i = NUM_AP - 1; i >= 0; i--) begin
      if (trig[i]) begin
        first_id  = 3'(i);
        first_val = ap_hit_value_flat[32*i +: 32];
      end
    end
  end

  assign any_trig = |trig;
  assign halt_nxt = |(trig & ap_action);
  assign clr_eff  = asr_clear & (state != REQ);
  assign capture  = any_trig &
                    ((state == IDLE) |
                     ((state == DONE) & asr_clear));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_trig) state_nxt = REQ;
      REQ:     if (bus.ap_ack) state_nxt = DONE;
      DONE:    if (asr_clear)
                 state_nxt = any_trig ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_debug) begin
    if (!rst_a)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  assign bus.ap_req = (state == REQ);

  always_ff @(posedge clk_debug) begin
    if (!rst_a) begin
      asr_r              <= '0;
      bus.ap_req_halt    <= 1'b0;
      bus.ap_hit_id_r    <= '0;
      bus.ap_hit_value_r <= '0;
      for (int p = 0; p < NP; p++)
        cnt[p] <= '0;
    end else begin
      asr_r <= (clr_eff ? '0 : asr_r) | trig;
      for (int p = 0; p < NP; p++)
        cnt[p] <= cnt_nxt[p];
      if (capture) begin
        bus.ap_req_halt    <= halt_nxt;
        bus.ap_hit_id_r    <= first_id;
        bus.ap_hit_value_r <= first_val;
      end
    end
  end
endmodule
